// File: rtl/sfq_rx_pkg.sv
// Shared types and defaults for the SFQ toggle-line receive blocks.
//   rx_state_t : receive FSM state encoding (IDLE, DATA, STOP)
//   *_DEF      : default parameter values for the receiver
//   clog2      : counter width helper, never returns less than 1
package sfq_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } rx_state_t;

  localparam int WIDTH_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/sfq_toggle_sync.sv
// Synchronizer and edge detector for a toggle-encoded SFQ pulse line.
//   clk   in  sampling clock, rising edge
//   rst   in  asynchronous, active-high reset
//   line  in  toggle-encoded line, asynchronous to clk
//   evt   out registered 1-cycle strobe, one per detected level change
module sfq_toggle_sync
  import sfq_rx_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   prime_q;
  logic                   prev;
  logic                   prime;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];
  // The chain comes out of reset holding 0, so a line parked at 1 would look
  // like an edge while the chain fills. prime stays high until the chain and
  // prev both carry real line samples; no evt is raised before that.
  assign prime = prime_q[SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      prime_q <= '1;
      prev    <= 1'b0;
      evt     <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], line};
      prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b0};
      prev    <= sync_out;
      evt     <= !prime && (sync_out ^ prev);
    end
  end

endmodule

// File: rtl/sfq_toggle_rx.sv
// Receive end of the toggle-encoded SFQ pulse line. Every level change is one
// pulse; a frame is a start pulse, WIDTH data slots (LSB first, pulse = 1) and
// an empty stop slot. Completed words go to a one-entry valid/ready buffer.
//   clk        in   sampling clock, rising edge
//   rst        in   asynchronous, active-high reset
//   in         in   toggle-encoded line, asynchronous to clk
//   enable     in   1 = receive frames, 0 = abort and hold in IDLE
//   data_out   out  received word, stable while valid=1
//   valid      out  word available
//   ready      in   consumer accepts word on valid&ready at clk edge
//   frame_err  out  1-cycle pulse: stop slot carried a pulse
//   overrun    out  1-cycle pulse: completed word dropped, buffer full
//   pulse_cnt  out  free-running count of detected pulses (wraps)
module sfq_toggle_rx
  import sfq_rx_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             enable,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             frame_err,
  output logic             overrun,
  output logic [CNT_W-1:0] pulse_cnt
);

  localparam int             BCW       = clog2(WIDTH);
  localparam logic [BCW-1:0] LAST_SLOT = BCW'(WIDTH - 1);

  rx_state_t        state;
  logic [BCW-1:0]   bit_cnt;
  logic [WIDTH-1:0] sreg;
  logic             evt;
  logic             word_done;
  logic             stop_err;
  logic             pop;

  sfq_toggle_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .line (in),
    .evt  (evt)
  );

  // Stop slot decides the frame; dropping enable there discards silently.
  assign word_done = (state == STOP) && enable && !evt;
  assign stop_err  = (state == STOP) && enable && evt;
  assign pop       = valid && ready;

  // Frame sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (evt && enable) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (!enable) begin
            state <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
            if (bit_cnt == LAST_SLOT) state <= STOP;
          end
        end
        // A pulse in the stop slot is consumed as the error, never as a start.
        STOP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Data slots shift in from the top so slot 0 lands in bit 0 after WIDTH slots.
  always_ff @(posedge clk) begin
    if ((state == DATA) && enable) sreg <= {evt, sreg[WIDTH-1:1]};
  end

  // Output buffer, flags and pulse counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      frame_err <= stop_err;
      overrun   <= word_done && valid && !ready;
      pulse_cnt <= pulse_cnt + CNT_W'(evt);
      // A pop in the same cycle frees the slot, so the new word replaces it.
      if (word_done && (!valid || ready)) begin
        data_out <= sreg;
        valid    <= 1'b1;
      end else if (pop) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sfq_toggle_rx.sv
// Bench for sfq_toggle_rx (WIDTH=8, SYNC_STAGES=2, CNT_W=16).
// Stimulus is a per-cycle slot stream: a 1 toggles the line at that negedge.
module tb_sfq_toggle_rx;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in;
  logic        enable;
  logic        ready;
  logic [7:0]  data_out;
  logic        valid;
  logic        frame_err;
  logic        overrun;
  logic [15:0] pulse_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_pcnt;
  bit          stim_q[$];
  logic [7:0]  got_q[$];
  int          n_ferr = 0;
  int          n_ovr  = 0;

  always #5 clk = ~clk;

  sfq_toggle_rx #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .enable    (enable),
    .data_out  (data_out),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .pulse_cnt (pulse_cnt)
  );

  // Records accepted words and flag pulses; values are stable mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (valid && ready) got_q.push_back(data_out);
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
      end
    end
  end

  task automatic push_frame(input logic [7:0] d, input bit stop_pulse);
    stim_q.push_back(1'b1);
    for (int i = 0; i < W; i++) stim_q.push_back(d[i]);
    stim_q.push_back(stop_pulse);
  endtask

  task automatic push_gap(input int n);
    repeat (n) stim_q.push_back(1'b0);
  endtask

  task automatic toggle_line();
    in = ~in;
    exp_pcnt++;
  endtask

  task automatic drive_stim(input int en_off_at, input int en_on_at);
    for (int n = 0; n < stim_q.size(); n++) begin
      @(negedge clk);
      if (n == en_off_at) enable = 1'b0;
      if (n == en_on_at) enable = 1'b1;
      if (stim_q[n]) toggle_line();
    end
    stim_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    got_q.delete();
    n_ferr = 0;
    n_ovr  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in = 1'b0; enable = 1'b1; ready = 1'b1; exp_pcnt = '0;
    idle(3);
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_out); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (pulse_cnt !== 16'h0) begin errors++; $display("FAIL reset_pulse_cnt got %h want 0", pulse_cnt); end
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    clear_mon();
  endtask

  // Start toggle before posedge 1 -> evt 3 cycles later -> valid 10 cycles after that.
  task automatic test_single_frame();
    clear_mon();
    push_frame(8'h85, 1'b0);
    for (int n = 0; n < 18; n++) begin
      @(negedge clk);
      if (n < stim_q.size() && stim_q[n]) toggle_line();
      #1;
      checks++;
      if (valid !== (n == 13)) begin
        errors++; $display("FAIL latency_valid cycle %0d got %b want %b", n, valid, (n == 13));
      end
      if (n == 13) begin
        checks++; if (data_out !== 8'h85) begin errors++; $display("FAIL single_data got %h want 85", data_out); end
      end
    end
    stim_q.delete();
    idle(4);
    #1;
    checks++; if (pulse_cnt !== 16'd4) begin errors++; $display("FAIL single_pulse_cnt got %0d want 4", pulse_cnt); end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_word_count got %0d want 1", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    ready = 1'b0;
    push_frame(8'hFF, 1'b0);
    push_frame(8'h01, 1'b0);
    drive_stim(-1, -1);
    idle(16);
    #1;
    checks++; if (n_ovr != 1) begin errors++; $display("FAIL b2b_overrun_pulses got %0d want 1", n_ovr); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_held got %b want 1", valid); end
    checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL b2b_held_word got %h want ff", data_out); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL b2b_no_accept got %0d want 0", got_q.size()); end
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got %b want 0", valid); end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'hFF) begin
      errors++; $display("FAIL b2b_accepted count %0d want 1 of ff", got_q.size());
    end
    checks++; if (pulse_cnt !== exp_pcnt) begin errors++; $display("FAIL b2b_pulse_cnt got %0d want %0d", pulse_cnt, exp_pcnt); end
  endtask

  task automatic test_stop_error();
    clear_mon();
    push_frame(8'h3C, 1'b1);
    push_frame(8'hA5, 1'b0);
    drive_stim(-1, -1);
    idle(16);
    #1;
    checks++; if (n_ferr != 1) begin errors++; $display("FAIL stop_err_pulses got %0d want 1", n_ferr); end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
      errors++; $display("FAIL stop_err_words count %0d want 1 of a5", got_q.size());
    end
    checks++; if (n_ovr != 0) begin errors++; $display("FAIL stop_err_overrun got %0d want 0", n_ovr); end
  endtask

  task automatic test_prime_level();
    @(negedge clk);
    rst = 1'b1; in = 1'b1; exp_pcnt = '0;
    idle(3);
    rst = 1'b0;
    idle(20);
    clear_mon();
    #1;
    checks++; if (pulse_cnt !== 16'd0) begin errors++; $display("FAIL prime_pulse_cnt got %0d want 0", pulse_cnt); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL prime_valid got %b want 0", valid); end
    push_frame(8'hC3, 1'b0);
    drive_stim(-1, -1);
    idle(16);
    #1;
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'hC3) begin
      errors++; $display("FAIL prime_next_frame count %0d want 1 of c3", got_q.size());
    end
    checks++; if (pulse_cnt !== exp_pcnt) begin errors++; $display("FAIL prime_count_after got %0d want %0d", pulse_cnt, exp_pcnt); end
  endtask

  // enable falls just before the edge that takes data slot 4.
  task automatic test_enable_abort();
    clear_mon();
    push_frame(8'hFF, 1'b0);
    push_gap(8);
    push_frame(8'h5A, 1'b0);
    drive_stim(8, 16);
    idle(16);
    #1;
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin
      errors++; $display("FAIL abort_words count %0d want 1 of 5a", got_q.size());
    end
    checks++; if (n_ferr != 0) begin errors++; $display("FAIL abort_frame_err got %0d want 0", n_ferr); end
    checks++; if (n_ovr != 0) begin errors++; $display("FAIL abort_overrun got %0d want 0", n_ovr); end
    checks++; if (pulse_cnt !== exp_pcnt) begin errors++; $display("FAIL abort_pulse_cnt got %0d want %0d", pulse_cnt, exp_pcnt); end
  endtask

  task automatic test_random();
    bit         exp_bits[$];
    logic [7:0] exp_words[$];
    logic [7:0] w;
    int         exp_err;
    int         i;
    clear_mon();
    enable = 1'b1; ready = 1'b1;
    for (int f = 0; f < 30; f++) begin
      push_gap(int'($urandom_range(0, 3)));
      push_frame(8'($urandom), ($urandom_range(0, 4) == 0));
    end
    exp_bits = stim_q;
    // Frame-level parse: a 1 while hunting is a start, then 8 data slots and a stop.
    i = 0; exp_err = 0;
    while (i < exp_bits.size()) begin
      if (exp_bits[i]) begin
        for (int j = 0; j < W; j++) w[j] = exp_bits[i + 1 + j];
        if (exp_bits[i + W + 1]) exp_err++;
        else exp_words.push_back(w);
        i += W + 2;
      end else begin
        i++;
      end
    end
    drive_stim(-1, -1);
    idle(16);
    #1;
    checks++; if (got_q.size() != exp_words.size()) begin errors++; $display("FAIL rand_word_count got %0d want %0d", got_q.size(), exp_words.size()); end
    for (int k = 0; k < exp_words.size() && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== exp_words[k]) begin errors++; $display("FAIL rand_word %0d got %h want %h", k, got_q[k], exp_words[k]); end
    end
    checks++; if (n_ferr != exp_err) begin errors++; $display("FAIL rand_frame_err got %0d want %0d", n_ferr, exp_err); end
    checks++; if (n_ovr != 0) begin errors++; $display("FAIL rand_overrun got %0d want 0", n_ovr); end
    checks++; if (pulse_cnt !== exp_pcnt) begin errors++; $display("FAIL rand_pulse_cnt got %0d want %0d", pulse_cnt, exp_pcnt); end
  endtask

  task automatic test_async_reset();
    clear_mon();
    ready = 1'b1; enable = 1'b1;
    @(negedge clk); toggle_line();
    @(negedge clk); toggle_line();
    idle(5);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL arst_data_valid got %b want 0", valid); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL arst_data_word got %h want 00", data_out); end
    checks++; if (pulse_cnt !== 16'h0) begin errors++; $display("FAIL arst_pulse_cnt got %0d want 0", pulse_cnt); end
    @(negedge clk);
    rst = 1'b0; exp_pcnt = '0;
    idle(6);
    ready = 1'b0;
    push_frame(8'h96, 1'b0);
    drive_stim(-1, -1);
    idle(16);
    #1;
    checks++; if (valid !== 1'b1 || data_out !== 8'h96) begin errors++; $display("FAIL arst_pre_hold got %b/%h want 1/96", valid, data_out); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL arst_held_valid got %b want 0", valid); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL arst_held_word got %h want 00", data_out); end
    @(negedge clk);
    rst = 1'b0; exp_pcnt = '0; ready = 1'b1;
    idle(6);
    // Counter wrap with the FSM held idle.
    enable = 1'b0;
    for (int k = 0; k < 65535; k++) begin
      @(negedge clk);
      toggle_line();
    end
    idle(5);
    #1;
    checks++; if (pulse_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_max got %h want ffff", pulse_cnt); end
    @(negedge clk);
    toggle_line();
    idle(5);
    #1;
    checks++; if (pulse_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h want 0000", pulse_cnt); end
    enable = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in = 1'b0; enable = 1'b1; ready = 1'b1; exp_pcnt = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stop_error();
    test_prime_level();
    test_enable_abort();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
